// File: rtl/mips_alu.sv
// Execute-stage ALU: combinational MIPS opcode/func decode, registered result/zero/overflow.
// Define ALU_MULT_EN to implement func 24 (mult, low word); otherwise func 24 decodes as unsupported.
module mips_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value1,
  input  logic [31:0] value2,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;

  localparam logic [5:0] FN_SLLV  = 6'd4;
  localparam logic [5:0] FN_SRLV  = 6'd6;
  localparam logic [5:0] FN_SRAV  = 6'd7;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] sra_res;
  logic        add_ovf;
  logic        sub_ovf;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [31:0] next_result;
  logic        next_ovf;

  assign sum         = value1 + value2;
  assign diff        = value1 - value2;
  assign sra_res     = $signed(value2) >>> value1[4:0];
  // Same-sign operands (A and ~B for subtraction) yielding an opposite-sign result.
  assign add_ovf     = (value1[31] == value2[31]) && (sum[31] != value1[31]);
  assign sub_ovf     = (value1[31] != value2[31]) && (diff[31] != value1[31]);
  assign lt_signed   = $signed(value1) < $signed(value2);
  assign lt_unsigned = value1 < value2;

`ifdef ALU_MULT_EN
  logic [31:0] prod;
  // Low word of a signed product equals the low word of the 32-bit wrapped multiply.
  assign prod = $signed(value1) * $signed(value2);
`endif

  always_comb begin
    next_result = '0;
    next_ovf    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin next_result = sum; next_ovf = add_ovf; end
          FN_ADDU: next_result = sum;
          FN_SUB:  begin next_result = diff; next_ovf = sub_ovf; end
          FN_SUBU: next_result = diff;
          FN_AND:  next_result = value1 & value2;
          FN_OR:   next_result = value1 | value2;
          FN_XOR:  next_result = value1 ^ value2;
          FN_NOR:  next_result = ~(value1 | value2);
          FN_SLT:  next_result = {31'd0, lt_signed};
          FN_SLTU: next_result = {31'd0, lt_unsigned};
          FN_SLLV: next_result = value2 << value1[4:0];
          FN_SRLV: next_result = value2 >> value1[4:0];
          FN_SRAV: next_result = sra_res;
`ifdef ALU_MULT_EN
          FN_MULT: next_result = prod;
`endif
          default: next_result = '0;
        endcase
      end
      OP_ADDI:  begin next_result = sum; next_ovf = add_ovf; end
      OP_ADDIU: next_result = sum;
      OP_SLTI:  next_result = {31'd0, lt_signed};
      OP_SLTIU: next_result = {31'd0, lt_unsigned};
      OP_ANDI:  next_result = value1 & value2;
      OP_ORI:   next_result = value1 | value2;
      OP_XORI:  next_result = value1 ^ value2;
      OP_LUI:   next_result = {value2[15:0], 16'h0000};
      default:  next_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      result   <= next_result;
      zero     <= (next_result == 32'd0);
      overflow <= next_ovf;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: expectations queued at issue, compared one edge later.
module tb_mips_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value1 = 32'h1234_5678;
  logic [31:0] value2 = 32'h9abc_def0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  func = 6'd32;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  mips_alu dut (
    .clk(clk),
    .rst_n(rst_n),
    .value1(value1),
    .value2(value2),
    .opcode(opcode),
    .func(func),
    .result(result),
    .zero(zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] res, input logic ovf);
    exp_t e;
    @(negedge clk);
    value1 = a;
    value2 = b;
    opcode = op;
    func   = fn;
    e.tag = tag;
    e.res = res;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".result"}, result, e.res);
      check({e.tag, ".zero"}, {31'd0, zero}, {31'd0, (e.res == 32'd0)});
      check({e.tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
    end
  end

  logic [31:0] mult_exp;

  initial begin
`ifdef ALU_MULT_EN
    mult_exp = 32'd6;
`else
    mult_exp = 32'd0;
`endif
    // Reset held with arbitrary inputs: outputs stay at reset values across edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      value1 = $urandom;
      value2 = $urandom;
      check("rst.result", result, 32'd0);
      check("rst.zero", {31'd0, zero}, 32'd1);
      check("rst.ovf", {31'd0, overflow}, 32'd0);
    end
    @(negedge clk);
    value1 = 32'd2; value2 = 32'd3; opcode = 6'd0; func = 6'd32;
    rst_n = 1'b1;
    #1;
    check("rel.result", result, 32'd0);
    check("rel.zero", {31'd0, zero}, 32'd1);

    // R-type, A=2 B=3
    issue("add",   32'd2, 32'd3, 6'd0, 6'd32, 32'd5, 1'b0);
    issue("addu",  32'd2, 32'd3, 6'd0, 6'd33, 32'd5, 1'b0);
    issue("sub",   32'd2, 32'd3, 6'd0, 6'd34, 32'hFFFF_FFFF, 1'b0);
    issue("subu",  32'd2, 32'd3, 6'd0, 6'd35, 32'hFFFF_FFFF, 1'b0);
    issue("and",   32'd2, 32'd3, 6'd0, 6'd36, 32'd2, 1'b0);
    issue("or",    32'd2, 32'd3, 6'd0, 6'd37, 32'd3, 1'b0);
    issue("xor",   32'd2, 32'd3, 6'd0, 6'd38, 32'd1, 1'b0);
    issue("nor",   32'd2, 32'd3, 6'd0, 6'd39, 32'hFFFF_FFFC, 1'b0);
    issue("slt",   32'd2, 32'd3, 6'd0, 6'd42, 32'd1, 1'b0);
    issue("mult",  32'd2, 32'd3, 6'd0, 6'd24, mult_exp, 1'b0);
    issue("sllv",  32'd4, 32'd3, 6'd0, 6'd4, 32'h0000_0030, 1'b0);
    // I-type, A=2 B=3
    issue("addi",  32'd2, 32'd3, 6'd8,  6'd0, 32'd5, 1'b0);
    issue("addiu", 32'd2, 32'd3, 6'd9,  6'd0, 32'd5, 1'b0);
    issue("slti",  32'd2, 32'd3, 6'd10, 6'd0, 32'd1, 1'b0);
    issue("sltiu", 32'd2, 32'd3, 6'd11, 6'd0, 32'd1, 1'b0);
    issue("andi",  32'd2, 32'd3, 6'd12, 6'd0, 32'd2, 1'b0);
    issue("ori",   32'd2, 32'd3, 6'd13, 6'd0, 32'd3, 1'b0);
    issue("xori",  32'd2, 32'd3, 6'd14, 6'd0, 32'd1, 1'b0);
    issue("lui",   32'd2, 32'd3, 6'd15, 6'd0, 32'h0003_0000, 1'b0);
    // Overflow boundaries
    issue("add_ov",  32'h7FFF_FFFF, 32'd1, 6'd0, 6'd32, 32'h8000_0000, 1'b1);
    issue("addu_ov", 32'h7FFF_FFFF, 32'd1, 6'd0, 6'd33, 32'h8000_0000, 1'b0);
    issue("addi_ov", 32'h7FFF_FFFF, 32'd1, 6'd8, 6'd0,  32'h8000_0000, 1'b1);
    issue("sub_ov",  32'h8000_0000, 32'd1, 6'd0, 6'd34, 32'h7FFF_FFFF, 1'b1);
    issue("subu_ov", 32'h8000_0000, 32'd1, 6'd0, 6'd35, 32'h7FFF_FFFF, 1'b0);
    issue("sub_ovp", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 6'd0, 6'd34, 32'h8000_0000, 1'b1);
    issue("add_ovn", 32'h8000_0000, 32'h8000_0000, 6'd0, 6'd32, 32'd0, 1'b1);
    issue("add_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 6'd32, 32'hFFFF_FFFE, 1'b0);
    // Shifts and compares
    issue("srav",  32'd4, 32'h8000_0000, 6'd0, 6'd7, 32'hF800_0000, 1'b0);
    issue("srlv",  32'd4, 32'h8000_0000, 6'd0, 6'd6, 32'h0800_0000, 1'b0);
    issue("srav_m", 32'h0000_0024, 32'h8000_0000, 6'd0, 6'd7, 32'hF800_0000, 1'b0);
    issue("sltu",  32'd1, 32'hFFFF_FFFF, 6'd0, 6'd43, 32'd1, 1'b0);
    issue("slt_n", 32'd1, 32'hFFFF_FFFF, 6'd0, 6'd42, 32'd0, 1'b0);
    // Zero flag and illegal decode
    issue("sub_z",  32'd7, 32'd7, 6'd0, 6'd34, 32'd0, 1'b0);
    issue("op63",   32'h7FFF_FFFF, 32'd1, 6'd63, 6'd32, 32'd0, 1'b0);
    issue("fn5",    32'd2, 32'd3, 6'd0, 6'd5, 32'd0, 1'b0);
    issue("lui_hi", 32'd0, 32'hABCD_1234, 6'd15, 6'd0, 32'h1234_0000, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    check("drain", sb.size(), 32'd0);

    // Asynchronous reset mid-operation clears the held nonzero result immediately.
    @(negedge clk);
    value1 = 32'd2; value2 = 32'd3; opcode = 6'd0; func = 6'd32;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.result", result, 32'd0);
    check("arst.zero", {31'd0, zero}, 32'd1);
    @(posedge clk);
    #1;
    check("arst_hold.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_rel.result", result, 32'd0);
    @(posedge clk);
    #2;
    check("arst_post.result", result, 32'd5);
    check("arst_post.zero", {31'd0, zero}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
